fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Owns the framebuffer's single write port (write_enable/data_in/data_in_x/data_in_y).
//  Shares it round-robin between two pixel writers (e.g. sprite renderer, HUD drawer).
//  Built-in clear engine sweeps the full frame with one colour on request.
//  Sits between the drawing logic and the framebuffer; the read side is untouched.
// PARAMETERS
//  WIDTH    320  frame width in pixels (framebuffer x range 0..WIDTH-1)
//  HEIGHT   240  frame height in pixels (y range 0..HEIGHT-1)
//  DATA_W   8    pixel colour width
//  COORD_W  11   coordinate width, matches framebuffer port
// PORTS
//  CLOCK_50        in   1        system clock, all logic on posedge
//  reset           in   1        synchronous, active-low reset
//  clear_start     in   1        request full-frame clear (sampled only in IDLE)
//  clear_color     in   DATA_W   clear colour, latched on the clear_start accept cycle
//  clear_busy      out  1        high while in CLEAR
//  clear_done      out  1        one-cycle pulse after the last clear write is issued
//  reqN_valid      in   1        N=0,1: writer N has a pixel
//  reqN_ready      out  1        N=0,1: pixel accepted this cycle (valid&ready)
//  reqN_data       in   DATA_W   N=0,1: pixel colour
//  reqN_x, reqN_y  in   COORD_W  N=0,1: pixel coordinates
//  fb_write_enable out  1        to framebuffer write_enable
//  fb_data_in      out  DATA_W   to framebuffer data_in
//  fb_data_in_x/_y out  COORD_W  to framebuffer data_in_x/data_in_y
//  drop_count      out  16       out-of-range writes dropped (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, all outputs 0, last_grant=1, counters 0.
//   Reset mid-clear aborts the sweep; no clear_done.
//  States: IDLE -> CLEAR on clear_start; CLEAR -> IDLE after write (WIDTH-1,HEIGHT-1).
//  IDLE arbitration (combinational ready):
//   - one valid -> that writer gets ready=1
//   - both valid -> writer != last_grant wins; first tie after reset goes to req0
//   - last_grant updates only on an accepted transfer; max one accept per cycle
//   - writers must not make valid depend on ready
//  clear_start in IDLE has priority: both reqN_ready=0 that cycle, state=CLEAR next.
//  clear_start while in CLEAR is ignored.
//  Write path: registered, 1-cycle latency.
//   - accept at cycle T -> fb_* carry that pixel at T+1 with fb_write_enable=1
//   - otherwise fb_write_enable=0 and fb_data_* hold their previous values
//  CLEAR: x,y counters start at (0,0); one write per cycle, x increments first.
//   - x wraps WIDTH-1 -> 0 with y+1
//   - exactly WIDTH*HEIGHT writes of the latched colour, on consecutive cycles
//   - reqN_ready=0 throughout; clear_busy=1 from the cycle after accept
//   - clear_done=1 the cycle after the last write; clear_busy=0 that same cycle
// CONFIGURATION
//  FB_BOUNDS_CHECK_EN defined:
//   - accepted pixel with x>=WIDTH or y>=HEIGHT is consumed (ready=1), no write issued
//   - drop_count increments, saturating at 16'hFFFF
//  Undefined: pixels are forwarded unchanged; drop_count is tied to 0.
// TESTING
//  reset, clear_start=1 with clear_color=8'h1C -> 76800 writes
//   first (0,0), last (319,239); clear_done one pulse on the next cycle.
//  req0/req1 valid continuously -> acceptances alternate 0,1,0,1 starting with req0
//   fb_write_enable high every cycle from the second cycle on.
//  req1 only, (x=5,y=7,data=8'hAA) -> req1_ready same cycle
//   next cycle fb_write_enable=1, fb_data_in_x=5, fb_data_in_y=7, fb_data_in=8'hAA.
//  clear_start and req0_valid in the same cycle -> req0_ready=0 until clear_done
//   req0 accepted the cycle after clear_done.
//  reset=0 at clear pixel 1000 -> next cycle all outputs 0, clear_busy=0
//   clear_done never pulses.
//  FB_BOUNDS_CHECK_EN: req0 x=320 -> ready=1, no write, drop_count=1
//   same stimulus without the macro -> write forwarded with x=320.

Source files
------------

// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if: request, clear-control and framebuffer write-port bundle for fb_write_arbiter
//   clear_start/clear_color      clear request and colour (latched on accept)
//   clear_busy/clear_done        sweep in progress / one-cycle completion pulse
//   reqN_valid/ready/data/x/y    pixel writer N handshake and payload (N=0,1)
//   fb_write_enable/fb_data_in*  registered framebuffer write port
//   drop_count                   out-of-range pixels discarded (bounds-check builds only)
//   modport master: drawing side; modport slave: the arbiter
interface fb_write_arbiter_if #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 11
);
    logic               clear_start;
    logic [DATA_W-1:0]  clear_color;
    logic               clear_busy;
    logic               clear_done;
    logic               req0_valid;
    logic               req0_ready;
    logic [DATA_W-1:0]  req0_data;
    logic [COORD_W-1:0] req0_x;
    logic [COORD_W-1:0] req0_y;
    logic               req1_valid;
    logic               req1_ready;
    logic [DATA_W-1:0]  req1_data;
    logic [COORD_W-1:0] req1_x;
    logic [COORD_W-1:0] req1_y;
    logic               fb_write_enable;
    logic [DATA_W-1:0]  fb_data_in;
    logic [COORD_W-1:0] fb_data_in_x;
    logic [COORD_W-1:0] fb_data_in_y;
    logic [15:0]        drop_count;

    modport master (
        output clear_start, clear_color,
        output req0_valid, req0_data, req0_x, req0_y,
        output req1_valid, req1_data, req1_x, req1_y,
        input  clear_busy, clear_done, req0_ready, req1_ready,
        input  fb_write_enable, fb_data_in, fb_data_in_x, fb_data_in_y, drop_count
    );

    modport slave (
        input  clear_start, clear_color,
        input  req0_valid, req0_data, req0_x, req0_y,
        input  req1_valid, req1_data, req1_x, req1_y,
        output clear_busy, clear_done, req0_ready, req1_ready,
        output fb_write_enable, fb_data_in, fb_data_in_x, fb_data_in_y, drop_count
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin owner of the framebuffer write port with a full-frame clear engine
//   CLOCK_50  system clock (posedge)
//   reset     synchronous, active-low
//   bus       fb_write_arbiter_if.slave: clear control, two pixel writers, fb write port, drop_count
//   Optional macro FB_BOUNDS_CHECK_EN: discard and count pixels outside WIDTH x HEIGHT.
module fb_write_arbiter #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int DATA_W  = 8,
    parameter int COORD_W = 11
) (
    input logic               CLOCK_50,
    input logic               reset,
    fb_write_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_nx;
    logic               last_grant;
    logic [COORD_W-1:0] cx, cy;
    logic [DATA_W-1:0]  color;
    logic               sweep_end, start, acc, in_range;
    logic [DATA_W-1:0]  sel_data;
    logic [COORD_W-1:0] sel_x, sel_y;

    assign sweep_end = cx == COORD_W'(WIDTH - 1) && cy == COORD_W'(HEIGHT - 1);
    assign acc       = bus.req0_ready || bus.req1_ready;
    assign sel_data  = bus.req1_ready ? bus.req1_data : bus.req0_data;
    assign sel_x     = bus.req1_ready ? bus.req1_x : bus.req0_x;
    assign sel_y     = bus.req1_ready ? bus.req1_y : bus.req0_y;

    always_ff @(posedge CLOCK_50)
        state <= !reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        if (state == IDLE && bus.clear_start) state_nx = CLEAR;
        if (state == CLEAR && sweep_end) state_nx = IDLE;
    end

    // Writers are held off during the clear_done cycle so the first post-clear accept follows the pulse.
    always_comb begin
        start          = state == IDLE && bus.clear_start;
        bus.req0_ready = state == IDLE && !bus.clear_start && !bus.clear_done &&
                         bus.req0_valid && (!bus.req1_valid || last_grant);
        bus.req1_ready = state == IDLE && !bus.clear_start && !bus.clear_done &&
                         bus.req1_valid && (!bus.req0_valid || !last_grant);
        bus.clear_busy = state == CLEAR;
    end

`ifdef FB_BOUNDS_CHECK_EN
    assign in_range = sel_x < COORD_W'(WIDTH) && sel_y < COORD_W'(HEIGHT);
    always_ff @(posedge CLOCK_50)
        if (!reset) bus.drop_count <= '0;
        else if (acc && !in_range && bus.drop_count != 16'hFFFF) bus.drop_count <= bus.drop_count + 16'd1;
`else
    assign in_range       = 1'b1;
    assign bus.drop_count = '0;
`endif

    always_ff @(posedge CLOCK_50)
        if (!reset) begin
            last_grant          <= 1'b1;
            cx                  <= '0;
            cy                  <= '0;
            color               <= '0;
            bus.clear_done      <= 1'b0;
            bus.fb_write_enable <= 1'b0;
            bus.fb_data_in      <= '0;
            bus.fb_data_in_x    <= '0;
            bus.fb_data_in_y    <= '0;
        end else begin
            bus.clear_done      <= state == CLEAR && sweep_end;
            bus.fb_write_enable <= state == CLEAR || (acc && in_range);
            if (state == CLEAR) begin
                bus.fb_data_in   <= color;
                bus.fb_data_in_x <= cx;
                bus.fb_data_in_y <= cy;
                cx               <= cx == COORD_W'(WIDTH - 1) ? '0 : cx + 1'b1;
                cy               <= cx == COORD_W'(WIDTH - 1) ? cy + 1'b1 : cy;
            end else if (acc && in_range) begin
                bus.fb_data_in   <= sel_data;
                bus.fb_data_in_x <= sel_x;
                bus.fb_data_in_y <= sel_y;
            end
            if (start) begin
                cx    <= '0;
                cy    <= '0;
                color <= bus.clear_color;
            end
            if (acc) last_grant <= bus.req1_ready;
        end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;
    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    int   errors   = 0;
    int   checks   = 0;

    fb_write_arbiter_if #(.DATA_W(8), .COORD_W(11)) bus ();
    fb_write_arbiter dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));

    initial forever #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        int good, leak, early, busy_bad, done_seen;
        bus.clear_start = 0; bus.clear_color = 0;
        bus.req0_valid = 0; bus.req0_data = 0; bus.req0_x = 0; bus.req0_y = 0;
        bus.req1_valid = 0; bus.req1_data = 0; bus.req1_x = 0; bus.req1_y = 0;
        tick(); tick();
        check("rst_we", 32'(bus.fb_write_enable), 0);
        check("rst_data", 32'(bus.fb_data_in), 0);
        check("rst_x", 32'(bus.fb_data_in_x), 0);
        check("rst_y", 32'(bus.fb_data_in_y), 0);
        check("rst_busy", 32'(bus.clear_busy), 0);
        check("rst_done", 32'(bus.clear_done), 0);
        check("rst_drop", 32'(bus.drop_count), 0);
        reset = 1;

        // both writers valid: 0,1,0,1 starting with req0
        bus.req0_valid = 1; bus.req0_data = 8'h10; bus.req0_x = 1; bus.req0_y = 1;
        bus.req1_valid = 1; bus.req1_data = 8'h20; bus.req1_x = 2; bus.req1_y = 2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
            check("rr_ready1", 32'(bus.req1_ready), 32'(i % 2 == 1));
            tick();
            check("rr_we", 32'(bus.fb_write_enable), 1);
            check("rr_data", 32'(bus.fb_data_in), i % 2 == 0 ? 32'h10 : 32'h20);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();
        check("idle_we", 32'(bus.fb_write_enable), 0);
        check("hold_data", 32'(bus.fb_data_in), 32'h20);
        check("hold_x", 32'(bus.fb_data_in_x), 2);

        // single writer req1
        bus.req1_valid = 1; bus.req1_data = 8'hAA; bus.req1_x = 5; bus.req1_y = 7;
        #1;
        check("r1_ready1", 32'(bus.req1_ready), 1);
        check("r1_ready0", 32'(bus.req0_ready), 0);
        tick();
        bus.req1_valid = 0;
        check("r1_we", 32'(bus.fb_write_enable), 1);
        check("r1_x", 32'(bus.fb_data_in_x), 5);
        check("r1_y", 32'(bus.fb_data_in_y), 7);
        check("r1_data", 32'(bus.fb_data_in), 32'hAA);

        // out-of-range pixels
        bus.req0_valid = 1; bus.req0_data = 8'h77; bus.req0_x = 320; bus.req0_y = 0;
        #1;
        check("oob_ready", 32'(bus.req0_ready), 1);
        tick();
        bus.req0_data = 8'h66; bus.req0_x = 319; bus.req0_y = 240;
`ifdef FB_BOUNDS_CHECK_EN
        check("oobx_we", 32'(bus.fb_write_enable), 0);
        check("oobx_drop", 32'(bus.drop_count), 1);
`else
        check("oobx_we", 32'(bus.fb_write_enable), 1);
        check("oobx_x", 32'(bus.fb_data_in_x), 320);
        check("oobx_drop", 32'(bus.drop_count), 0);
`endif
        tick();
        bus.req0_valid = 0;
`ifdef FB_BOUNDS_CHECK_EN
        check("ooby_we", 32'(bus.fb_write_enable), 0);
        check("ooby_drop", 32'(bus.drop_count), 2);
`else
        check("ooby_we", 32'(bus.fb_write_enable), 1);
        check("ooby_y", 32'(bus.fb_data_in_y), 240);
`endif
        tick();

        // clear with a competing req0
        bus.clear_start = 1; bus.clear_color = 8'h1C;
        bus.req0_valid = 1; bus.req0_data = 8'h55; bus.req0_x = 3; bus.req0_y = 4;
        #1;
        check("clr_acc_ready0", 32'(bus.req0_ready), 0);
        tick();
        bus.clear_start = 0;
        check("clr_busy", 32'(bus.clear_busy), 1);
        check("clr_first_we", 32'(bus.fb_write_enable), 0);
        good = 0; leak = 0; early = 0; busy_bad = 0;
        for (int n = 0; n < 76800; n++) begin
            tick();
            if (bus.fb_write_enable === 1'b1 && bus.fb_data_in === 8'h1C &&
                bus.fb_data_in_x === 11'(n % 320) && bus.fb_data_in_y === 11'(n / 320)) good++;
            if (bus.req0_ready !== 1'b0) leak++;
            if (n < 76799 && bus.clear_done !== 1'b0) early++;
            if (bus.clear_busy !== (n < 76799)) busy_bad++;
        end
        check("clr_writes", 32'(good), 76800);
        check("clr_ready_leak", 32'(leak), 0);
        check("clr_early_done", 32'(early), 0);
        check("clr_busy_shape", 32'(busy_bad), 0);
        check("clr_last_x", 32'(bus.fb_data_in_x), 319);
        check("clr_last_y", 32'(bus.fb_data_in_y), 239);
        check("clr_done", 32'(bus.clear_done), 1);
        check("clr_done_busy", 32'(bus.clear_busy), 0);
        check("clr_done_ready0", 32'(bus.req0_ready), 0);
        tick();
        check("clr_done_pulse", 32'(bus.clear_done), 0);
        check("post_ready0", 32'(bus.req0_ready), 1);
        check("post_idle_we", 32'(bus.fb_write_enable), 0);
        tick();
        bus.req0_valid = 0;
        check("post_we", 32'(bus.fb_write_enable), 1);
        check("post_x", 32'(bus.fb_data_in_x), 3);
        check("post_y", 32'(bus.fb_data_in_y), 4);
        check("post_data", 32'(bus.fb_data_in), 32'h55);

        // reset during a clear
        bus.clear_start = 1; bus.clear_color = 8'h3C;
        tick();
        bus.clear_start = 0;
        repeat (1000) tick();
        check("mid_x", 32'(bus.fb_data_in_x), 39);
        check("mid_y", 32'(bus.fb_data_in_y), 3);
        reset = 0;
        tick();
        check("mid_rst_we", 32'(bus.fb_write_enable), 0);
        check("mid_rst_data", 32'(bus.fb_data_in), 0);
        check("mid_rst_x", 32'(bus.fb_data_in_x), 0);
        check("mid_rst_y", 32'(bus.fb_data_in_y), 0);
        check("mid_rst_busy", 32'(bus.clear_busy), 0);
        check("mid_rst_done", 32'(bus.clear_done), 0);
        check("mid_rst_drop", 32'(bus.drop_count), 0);
        reset = 1;
        done_seen = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (bus.clear_done !== 1'b0 || bus.clear_busy !== 1'b0) done_seen++;
        end
        check("mid_no_done", 32'(done_seen), 0);

        // first tie after reset goes to req0
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        check("tie_after_rst0", 32'(bus.req0_ready), 1);
        check("tie_after_rst1", 32'(bus.req1_ready), 0);
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
